// File: rtl/icache_pref_engine.sv
// Prefetch receiver for the I-cache: hit report, miss FIFO, memory issue and registered fills.
// Define PREF_DEDUP_EN to discard requests whose line is already queued or outstanding.
module icache_pref_engine #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned OUT_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pref2Icache_addr,
    input  logic        pref2Icache_valid,
    input  logic        icache_line_valid,
    output logic        hit_valid_line,
    input  logic        squash,
    input  logic        demand_busy,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_data_tag,
    output logic        fill_valid,
    output logic [31:0] fill_addr,
    output logic [63:0] fill_data,
    output logic        pref_drop
);
    localparam logic [1:0]  MEM_NONE = 2'h0;
    localparam logic [1:0]  MEM_LOAD = 2'h1;
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned SW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [28:0]          fifo_q [QUEUE_DEPTH];
    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [CW-1:0]        count_q;
    logic [OUT_DEPTH-1:0] slot_valid_q;
    logic [3:0]           slot_tag_q [OUT_DEPTH];
    logic [28:0]          slot_blk_q [OUT_DEPTH];
    logic                 fill_valid_q;
    logic [31:0]          fill_addr_q;
    logic [63:0]          fill_data_q;
    logic                 pref_drop_q;

    logic [28:0]   req_blk;
    logic          fifo_empty;
    logic          fifo_full;
    logic          free_any;
    logic [SW-1:0] free_idx;
    logic          match_any;
    logic [SW-1:0] match_idx;
    logic          dup;
    logic          issue;
    logic          accept;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          unused_addr_lsb;

    assign req_blk         = pref2Icache_addr[31:3];
    assign unused_addr_lsb = ^pref2Icache_addr[2:0];
    assign fifo_empty      = (count_q == '0);
    assign fifo_full       = (count_q == CW'(QUEUE_DEPTH));

    // Descending scan so the lowest index wins for both searches.
    always_comb begin
        free_any  = 1'b0;
        free_idx  = '0;
        match_any = 1'b0;
        match_idx = '0;
        for (int i = OUT_DEPTH - 1; i >= 0; i--) begin
            if (!slot_valid_q[i]) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
            if (slot_valid_q[i] && (mem2proc_data_tag != 4'd0) &&
                (slot_tag_q[i] == mem2proc_data_tag)) begin
                match_any = 1'b1;
                match_idx = SW'(i);
            end
        end
    end

`ifdef PREF_DEDUP_EN
    logic [PW-1:0] ofs;

    always_comb begin
        dup = 1'b0;
        ofs = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            ofs = PW'(i) - head_q;
            if (({1'b0, ofs} < count_q) && (fifo_q[i] == req_blk)) begin
                dup = 1'b1;
            end
        end
        for (int i = 0; i < OUT_DEPTH; i++) begin
            if (slot_valid_q[i] && (slot_blk_q[i] == req_blk)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign issue    = !fifo_empty && !demand_busy && free_any && !squash;
    assign accept   = issue && (mem2proc_transaction_tag != 4'd0);
    assign push_req = pref2Icache_valid && !icache_line_valid && !squash && !dup;
    // A pop in the same cycle frees the entry the push needs.
    assign push     = push_req && (!fifo_full || accept);
    assign drop     = push_req && fifo_full && !accept;

    assign hit_valid_line   = pref2Icache_valid & icache_line_valid;
    assign proc2mem_command = issue ? MEM_LOAD : MEM_NONE;
    assign proc2mem_addr    = issue ? {fifo_q[head_q], 3'b000} : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            slot_valid_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                slot_tag_q[i] <= '0;
                slot_blk_q[i] <= '0;
            end
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
            pref_drop_q  <= 1'b0;
        end else begin
            if (squash) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) begin
                    fifo_q[tail_q] <= req_blk;
                    tail_q         <= tail_q + 1'b1;
                end
                if (accept) begin
                    head_q <= head_q + 1'b1;
                end
                if (push && !accept) begin
                    count_q <= count_q + 1'b1;
                end else if (accept && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
            if (match_any) begin
                slot_valid_q[match_idx] <= 1'b0;
            end
            if (accept) begin
                slot_valid_q[free_idx] <= 1'b1;
                slot_tag_q[free_idx]   <= mem2proc_transaction_tag;
                slot_blk_q[free_idx]   <= fifo_q[head_q];
            end
            fill_valid_q <= match_any;
            fill_addr_q  <= match_any ? {slot_blk_q[match_idx], 3'b000} : 32'd0;
            fill_data_q  <= match_any ? mem2proc_data : 64'd0;
            pref_drop_q  <= drop;
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_addr  = fill_addr_q;
    assign fill_data  = fill_data_q;
    assign pref_drop  = pref_drop_q;

endmodule

// File: tb/tb_icache_pref_engine.sv
// Scoreboard bench for icache_pref_engine: queue-based reference model, separate output monitor.
module tb_icache_pref_engine;
    localparam int QD = 4;
    localparam int OD = 4;
    localparam logic [1:0] MEM_NONE = 2'h0;
    localparam logic [1:0] MEM_LOAD = 2'h1;
`ifdef PREF_DEDUP_EN
    localparam int EXP_LOADS_300 = 1;
`else
    localparam int EXP_LOADS_300 = 2;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pref2Icache_addr = '0;
    logic        pref2Icache_valid = 1'b0;
    logic        icache_line_valid = 1'b0;
    logic        hit_valid_line;
    logic        squash = 1'b0;
    logic        demand_busy = 1'b0;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_transaction_tag = '0;
    logic [63:0] mem2proc_data = '0;
    logic [3:0]  mem2proc_data_tag = '0;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [63:0] fill_data;
    logic        pref_drop;

    icache_pref_engine #(.QUEUE_DEPTH(QD), .OUT_DEPTH(OD)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .pref2Icache_addr         (pref2Icache_addr),
        .pref2Icache_valid        (pref2Icache_valid),
        .icache_line_valid        (icache_line_valid),
        .hit_valid_line           (hit_valid_line),
        .squash                   (squash),
        .demand_busy              (demand_busy),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data            (mem2proc_data),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .fill_valid               (fill_valid),
        .fill_addr                (fill_addr),
        .fill_data                (fill_data),
        .pref_drop                (pref_drop)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] addr;
        logic [63:0] data;
    } fill_t;

    // Reference model: waiting lines as a queue, outstanding lines as tagged slots.
    logic [28:0] mq[$];
    bit          m_valid [OD];
    logic [3:0]  m_tag   [OD];
    logic [28:0] m_blk   [OD];
    fill_t       fill_q[$];
    int          drop_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          loads_300 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_use(input logic [3:0] t);
        for (int i = 0; i < OD; i++) if (m_valid[i] && m_tag[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_valid();
        for (int i = 0; i < OD; i++) if (m_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] pick_free_tag();
        int s;
        logic [3:0] t;
        s = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
            t = 4'(((s - 1 + k) % 15) + 1);
            if (!in_use(t)) return t;
        end
        return 4'd0;
    endfunction

    function automatic logic [3:0] pick_busy_tag();
        logic [3:0] tags[$];
        for (int i = 0; i < OD; i++) if (m_valid[i]) tags.push_back(m_tag[i]);
        if (tags.size() == 0) return 4'd0;
        return tags[$urandom_range(0, tags.size() - 1)];
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < OD; i++) m_valid[i] = 1'b0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance the model.
    // txn/dtag < 0 mean "choose automatically".
    task automatic step(input logic rv, input logic [31:0] ra, input logic lv, input logic sq,
                        input logic db, input int txn, input int dtag, input logic [63:0] dat);
        int          free_i;
        int          match_i;
        bit          m_issue;
        bit          m_accept;
        bit          m_dup;
        bit          m_push_req;
        logic [28:0] b;
        logic [3:0]  tt;
        logic [3:0]  dt;
        fill_t       f;
        @(negedge clock);
        tt = (txn < 0) ? pick_free_tag() : 4'(txn);
        dt = (dtag < 0) ? pick_busy_tag() : 4'(dtag);
        pref2Icache_valid        = rv;
        pref2Icache_addr         = ra;
        icache_line_valid        = lv;
        squash                   = sq;
        demand_busy              = db;
        mem2proc_transaction_tag = tt;
        mem2proc_data_tag        = dt;
        mem2proc_data            = dat;
        #1;
        free_i  = -1;
        match_i = -1;
        for (int i = 0; i < OD; i++) begin
            if (!m_valid[i] && free_i < 0) free_i = i;
            if (m_valid[i] && dt != 4'd0 && m_tag[i] == dt && match_i < 0) match_i = i;
        end
        m_issue  = (mq.size() != 0) && !db && (free_i >= 0) && !sq;
        m_accept = m_issue && (tt != 4'd0);
        b        = ra[31:3];
        m_dup    = 1'b0;
`ifdef PREF_DEDUP_EN
        foreach (mq[k]) if (mq[k] == b) m_dup = 1'b1;
        for (int i = 0; i < OD; i++) if (m_valid[i] && m_blk[i] == b) m_dup = 1'b1;
`endif
        m_push_req = rv && !lv && !sq && !m_dup;
        check("hit_valid_line", 64'(hit_valid_line), 64'(rv & lv));
        check("proc2mem_command", 64'(proc2mem_command), 64'(m_issue ? MEM_LOAD : MEM_NONE));
        if (m_issue) check("proc2mem_addr", 64'(proc2mem_addr), 64'({mq[0], 3'b000}));
        if (proc2mem_command == MEM_LOAD && proc2mem_addr == 32'h300) loads_300++;
        if (match_i >= 0) begin
            f.at   = cyc + 1;
            f.addr = {m_blk[match_i], 3'b000};
            f.data = dat;
            fill_q.push_back(f);
            m_valid[match_i] = 1'b0;
        end
        if (m_accept) begin
            m_valid[free_i] = 1'b1;
            m_tag[free_i]   = tt;
            m_blk[free_i]   = mq.pop_front();
        end
        if (m_push_req) begin
            if (mq.size() < QD) mq.push_back(b);
            else drop_q.push_back(cyc + 1);
        end
        if (sq) mq.delete();
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (mq.size() != 0 || any_valid()); k++)
            step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, -1, -1, rand64());
        if (mq.size() != 0 || any_valid()) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d queued, outstanding still present", mq.size());
        end
        idle();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a fill or a drop.
    initial begin : monitor
        fill_t f;
        int    d;
        forever begin
            @(posedge clock);
            #1;
            if (fill_valid) begin
                if (fill_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_fill: got addr %0h, expected no fill (cycle %0d)",
                             fill_addr, cyc);
                end else begin
                    f = fill_q.pop_front();
                    check("fill_cycle", 64'(cyc), 64'(f.at));
                    check("fill_addr", 64'(fill_addr), 64'(f.addr));
                    check("fill_data", fill_data, f.data);
                end
            end
            if (pref_drop) begin
                if (drop_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_drop: got pref_drop=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    d = drop_q.pop_front();
                    check("drop_cycle", 64'(cyc), 64'(d));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0] old_a;
        logic [3:0] old_b;
        model_clear();
        #12;
        check("rst_fill_valid", 64'(fill_valid), 64'd0);
        check("rst_fill_addr", 64'(fill_addr), 64'd0);
        check("rst_fill_data", fill_data, 64'd0);
        check("rst_pref_drop", 64'(pref_drop), 64'd0);
        check("rst_command", 64'(proc2mem_command), 64'(MEM_NONE));
        check("rst_mem_addr", 64'(proc2mem_addr), 64'd0);
        #10 reset = 1'b1;

        // Basic path: issue next cycle with tag 3, data two cycles later.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3, 0, 64'd0);
        idle();
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 3, 64'hDEADBEEF_CAFEF00D);
        idle();

        // Cache hit: reported, not enqueued.
        step(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 0, 0, 64'd0);
        idle();

        // Full FIFO under demand priority.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + 32'(i * 8), 1'b0, 1'b0, 1'b1, 7, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 7, 0, 64'd0);
        drain();

        // Same-line requests.
        loads_300 = 0;
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0, -1, 0, 64'd0);
        drain();
        check("loads_0x300", 64'(loads_300), 64'(EXP_LOADS_300));

        // Memory rejects, then squash with two entries waiting.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(i * 8), 1'b0, 1'b0, 1'b1, 0, 0, 64'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 6, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 6, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 5, 64'h0123_4567_89AB_CDEF);
        idle();
        drain();

        // Asynchronous reset with two slots outstanding and a fill on the output.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(i * 8), 1'b0, 1'b0, 1'b1, 0, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, -1, 0, 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, -1, 0, 64'd0);
        step(1'b1, 32'h618, 1'b0, 1'b0, 1'b0, -1, int'(m_tag[0]), 64'h5555_AAAA_5555_AAAA);
        @(posedge clock);
        #3;
        check("pre_reset_command", 64'(proc2mem_command), 64'(MEM_LOAD));
        check("pre_reset_addr", 64'(proc2mem_addr), 64'h618);
        reset = 1'b0;
        #1;
        check("async_fill_valid", 64'(fill_valid), 64'd0);
        check("async_fill_addr", 64'(fill_addr), 64'd0);
        check("async_fill_data", fill_data, 64'd0);
        check("async_pref_drop", 64'(pref_drop), 64'd0);
        check("async_command", 64'(proc2mem_command), 64'(MEM_NONE));
        old_a = m_tag[1];
        old_b = m_tag[2];
        model_clear();
        pref2Icache_valid = 1'b0;
        mem2proc_transaction_tag = 4'd0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, int'(old_a), 64'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, int'(old_b), 64'd2);
        idle();

        // Randomized traffic over a small set of lines.
        for (int n = 0; n < 400; n++) begin
            int r;
            int txn;
            int dtag;
            r    = $urandom_range(0, 3);
            dtag = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 15) : -1;
            txn  = ($urandom_range(0, 3) == 0) ? 0 : -1;
            step(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 31) * 4),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 2) == 0), txn, dtag, rand64());
        end
        drain();
        idle();
        @(posedge clock);
        #2;
        check("pending_fills", 64'(fill_q.size()), 64'd0);
        check("pending_drops", 64'(drop_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_pref_engine.md
# icache_pref_engine

Receiving end of the instruction prefetch stream. Accepts line-prefetch requests from the prefetcher, reports whether the requested line already sits in the I-cache, queues and de-duplicates the misses, and issues them to memory whenever the I-cache demand path leaves the memory port idle. It tracks outstanding memory tags and returns completed lines to the I-cache as registered fills. It sits inside the I-cache, between the prefetcher and the memory arbiter.

## Interface
- `QUEUE_DEPTH`, 4: waiting-request FIFO entries; power of 2, at least 2.
- `OUT_DEPTH`, 4: outstanding-transaction slots; at least 1 and at most 15.
- `clock` in 1: single clock; all state is on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `pref2Icache_addr` in 32 (`ADDR`): byte address requested by the prefetcher.
- `pref2Icache_valid` in 1: request valid this cycle.
- `icache_line_valid` in 1: I-cache tag lookup of `pref2Icache_addr` hit a valid line (same cycle).
- `hit_valid_line` out 1: to the prefetcher; equals `pref2Icache_valid & icache_line_valid`; combinational.
- `squash` in 1: front-end redirect; flushes waiting requests.
- `demand_busy` in 1: I-cache demand miss owns the memory port this cycle.
- `proc2mem_command` out 2 (`MEM_COMMAND`): `MEM_LOAD` when issuing, else `MEM_NONE`.
- `proc2mem_addr` out 32: 8-byte-aligned line address.
- `mem2proc_transaction_tag` in 4 (`MEM_TAG`): nonzero means accepted; 0 means rejected.
- `mem2proc_data` in 64: returned line.
- `mem2proc_data_tag` in 4: tag of the returned line; 0 means no data.
- `fill_valid` out 1: registered fill pulse to the I-cache data array.
- `fill_addr` out 32: line address of the fill, with bits [2:0] = 0.
- `fill_data` out 64: line data.
- `pref_drop` out 1: registered pulse; a request was dropped because the FIFO was full.

## Operation
- Line address: `blk = pref2Icache_addr[31:3]`.
- Enqueue condition: `pref2Icache_valid & ~icache_line_valid & ~squash`, the FIFO is not full, and no duplicate exists (see Configuration).
- FIFO pointers are log2(QUEUE_DEPTH) bits and wrap. Empty and full are distinguished by a separate count of width clog2(QUEUE_DEPTH+1).
- Issue: the head entry issues when the FIFO is non-empty, `demand_busy` is 0, a free outstanding slot exists, and `squash` is 0.
  - Drive `proc2mem_command=MEM_LOAD` and `proc2mem_addr={head_blk,3'b0}`.
  - If `mem2proc_transaction_tag != 0`: pop the head and write {valid, tag, blk} into the lowest-index free slot.
  - If the tag is 0: keep the head and retry next cycle.
- Fill: when `mem2proc_data_tag != 0` matches a valid slot tag:
  - Next cycle, `fill_valid=1`, `fill_addr={slot_blk,3'b0}`, `fill_data=mem2proc_data`.
  - The matching slot is freed at the same edge.
  - Tags that match no slot (demand traffic) are ignored.
- Squash: clears the FIFO at the next edge. Outstanding slots are kept and still produce fills.
- Same-cycle push and pop on a full FIFO: the pop is applied first, so the push is accepted and the count is unchanged.
- A slot freed by a fill becomes usable for issue on the following cycle, not the same cycle.

## Timing
- Reset values:
  - All FIFO entries, slots and counts are 0.
  - `fill_valid=0`, `fill_addr=0`, `fill_data=0`, `pref_drop=0`.
  - `proc2mem_command=MEM_NONE`, `proc2mem_addr=0`.
- Request accepted at cycle t is eligible to issue at t+1 at the earliest.
- Data tag seen at cycle t produces `fill_valid` at t+1, for exactly one cycle per matching tag.
- `pref_drop` asserts at t+1 for a drop at t.
- `proc2mem_*` and `hit_valid_line` are combinational from current state and inputs.
- Reset asserted mid-transaction discards all slots. Later data tags match nothing and produce no fill.

## Configuration
- `PREF_DEDUP_EN` defined:
  - A request whose `blk` equals any valid FIFO entry or any valid outstanding slot is silently discarded.
  - A discarded duplicate is neither enqueued nor counted as a drop.
- `PREF_DEDUP_EN` undefined: every request that misses the I-cache is enqueued when space exists, duplicates included.

## Test plan
- Basic path:
  - Stimulus: reset, then request addr 0x100 with `icache_line_valid=0`; memory returns tag 3 on issue; two cycles later data tag 3 with data 0xDEADBEEF_CAFEF00D.
  - Response: `MEM_LOAD` to 0x100 at t+1; `fill_valid` with `fill_addr=0x100` and that data one cycle after the data tag.
- Cache hit:
  - Stimulus: request 0x200 with `icache_line_valid=1`.
  - Response: `hit_valid_line=1` the same cycle; no enqueue; no memory command.
- Full FIFO and demand priority:
  - Stimulus: `demand_busy=1` held; 5 distinct requests with QUEUE_DEPTH=4.
  - Response: the 5th request causes `pref_drop=1` for one cycle; no `MEM_LOAD` while `demand_busy` is 1.
- Dedup (`PREF_DEDUP_EN` defined):
  - Stimulus: requests 0x300 then 0x304.
  - Response: only one entry is created; exactly one `MEM_LOAD` to 0x300.
  - Without the macro: two `MEM_LOAD`s to 0x300.
- Memory reject, then squash:
  - Stimulus: transaction tag 0 for 3 cycles, then tag 5; assert `squash` while two other entries are waiting.
  - Response: the head retries until tag 5 is accepted; the waiting entries are flushed; the fill for tag 5 is still delivered.
- Asynchronous reset:
  - Stimulus: drop `reset` mid-cycle with 2 outstanding slots.
  - Response: outputs go to reset values immediately; subsequent data tags produce no `fill_valid`.
